// File: rtl/interval_timer_pkg.sv
// Shared constants for the interval-timer driver: timer register map, control/status
// bit positions, the driver FSM state set and the control-word builders.
package interval_timer_pkg;

  localparam int TMR_STATUS   = 0;
  localparam int TMR_CONTROL  = 1;
  localparam int TMR_PERIOD_L = 2;
  localparam int TMR_PERIOD_H = 3;
  localparam int TMR_SNAP_L   = 4;
  localparam int TMR_SNAP_H   = 5;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTL,
    S_WAIT_IRQ,
    S_RD_ST_A,
    S_RD_ST_D,
    S_CLR,
    S_WR_STOP
`ifdef INTERVAL_TIMER_DRIVER_SNAPSHOT_EN
    ,
    S_SN_W,
    S_SN_LA,
    S_SN_LD,
    S_SN_HD
`endif
  } state_t;

  // Start command: interrupt enabled, START set, CONT per requested mode.
  function automatic logic [15:0] ctl_start_word(input logic cont);
    logic [15:0] w;
    w            = '0;
    w[CTL_ITO]   = 1'b1;
    w[CTL_CONT]  = cont;
    w[CTL_START] = 1'b1;
    return w;
  endfunction

  // Stop command also drops ITO so a late timeout cannot raise irq again.
  function automatic logic [15:0] ctl_stop_word();
    logic [15:0] w;
    w           = '0;
    w[CTL_STOP] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/interval_timer_driver_if.sv
// Avalon-MM link between the interval-timer driver (master) and the timer s1 port (slave).
interface interval_timer_driver_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/interval_timer_driver.sv
// Hardware initiator for the interval timer: programs period/mode, services timeouts, emits ticks.
// Optional counter snapshot readout is built when INTERVAL_TIMER_DRIVER_SNAPSHOT_EN is defined.
module interval_timer_driver
  import interval_timer_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 16,
  parameter int TICK_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [31:0]           period,
  input  logic                  continuous,
  output logic                  busy,
  output logic                  tick,
  output logic [TICK_CNT_W-1:0] tick_count,
`ifdef INTERVAL_TIMER_DRIVER_SNAPSHOT_EN
  input  logic                  snap_req,
  output logic                  snap_valid,
  output logic [31:0]           snapshot,
`endif
  interval_timer_driver_if.master bus
);

  state_t            state;
  state_t            next_state;
  logic [31:0]       period_q;
  logic              cont_q;
  logic              stop_pend;
  logic              cs_d;
  logic              write_n_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
`ifdef INTERVAL_TIMER_DRIVER_SNAPSHOT_EN
  logic              snap_pend;
`endif

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (start) next_state = S_WR_PL;
      S_WR_PL:    next_state = S_WR_PH;
      S_WR_PH:    next_state = S_WR_CTL;
      S_WR_CTL:   next_state = S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        // Stop outranks a coincident irq; the timeout is then left for software.
        if (stop || stop_pend)
          next_state = S_WR_STOP;
        else if (bus.irq)
          next_state = S_RD_ST_A;
`ifdef INTERVAL_TIMER_DRIVER_SNAPSHOT_EN
        else if (snap_pend)
          next_state = S_SN_W;
`endif
      end
      S_RD_ST_A:  next_state = S_RD_ST_D;
      S_RD_ST_D:  next_state = bus.readdata[ST_TO] ? S_CLR : S_WAIT_IRQ;
      S_CLR:      next_state = cont_q ? S_WAIT_IRQ : S_IDLE;
      S_WR_STOP:  next_state = S_IDLE;
`ifdef INTERVAL_TIMER_DRIVER_SNAPSHOT_EN
      S_SN_W:     next_state = S_SN_LA;
      S_SN_LA:    next_state = S_SN_LD;
      S_SN_LD:    next_state = S_SN_HD;
      S_SN_HD:    next_state = S_WAIT_IRQ;
`endif
      default:    next_state = S_IDLE;
    endcase
  end

  // Bus cycle for the state being entered, so the registered outputs line up with it
  always_comb begin
    cs_d      = 1'b0;
    write_n_d = 1'b1;
    addr_d    = '0;
    wdata_d   = '0;
    case (next_state)
      S_WR_PL: begin
        // Entered only from IDLE, where period_q is loaded on the same edge.
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        addr_d    = ADDR_W'(TMR_PERIOD_L);
        wdata_d   = DATA_W'(period[15:0]);
      end
      S_WR_PH: begin
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        addr_d    = ADDR_W'(TMR_PERIOD_H);
        wdata_d   = DATA_W'(period_q[31:16]);
      end
      S_WR_CTL: begin
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        addr_d    = ADDR_W'(TMR_CONTROL);
        wdata_d   = DATA_W'(ctl_start_word(cont_q));
      end
      S_RD_ST_A: begin
        cs_d   = 1'b1;
        addr_d = ADDR_W'(TMR_STATUS);
      end
      S_CLR: begin
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        addr_d    = ADDR_W'(TMR_STATUS);
      end
      S_WR_STOP: begin
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        addr_d    = ADDR_W'(TMR_CONTROL);
        wdata_d   = DATA_W'(ctl_stop_word());
      end
`ifdef INTERVAL_TIMER_DRIVER_SNAPSHOT_EN
      S_SN_W: begin
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        addr_d    = ADDR_W'(TMR_SNAP_L);
      end
      S_SN_LA: begin
        cs_d   = 1'b1;
        addr_d = ADDR_W'(TMR_SNAP_L);
      end
      S_SN_LD: begin
        cs_d   = 1'b1;
        addr_d = ADDR_W'(TMR_SNAP_H);
      end
`endif
      default: ;
    endcase
  end

  // State, bus and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      cont_q         <= 1'b0;
      stop_pend      <= 1'b0;
      busy           <= 1'b0;
      tick           <= 1'b0;
      tick_count     <= '0;
      bus.chipselect <= 1'b0;
      bus.write_n    <= 1'b1;
      bus.address    <= '0;
      bus.writedata  <= '0;
    end else begin
      state          <= next_state;
      busy           <= (next_state != S_IDLE);
      tick           <= (next_state == S_CLR);
      bus.chipselect <= cs_d;
      bus.write_n    <= write_n_d;
      bus.address    <= addr_d;
      bus.writedata  <= wdata_d;
      if (state == S_IDLE && start)
        cont_q <= continuous;
      if (next_state == S_CLR)
        tick_count <= tick_count + TICK_CNT_W'(1);
      // A stop still pending when the run ends (one-shot CLR) has nothing left to stop.
      if (next_state == S_IDLE)
        stop_pend <= 1'b0;
      else if (stop && state != S_IDLE && state != S_WAIT_IRQ)
        stop_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && start)
      period_q <= period;
  end

`ifdef INTERVAL_TIMER_DRIVER_SNAPSHOT_EN
  // Snapshot capture: low half lands after SN_LD, high half after SN_HD
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_pend  <= 1'b0;
      snap_valid <= 1'b0;
      snapshot   <= '0;
    end else begin
      // A request arriving on the serving edge stays pending for a fresh snapshot.
      if (snap_req)
        snap_pend <= 1'b1;
      else if (state == S_WAIT_IRQ && next_state == S_SN_W)
        snap_pend <= 1'b0;
      snap_valid <= (state == S_SN_HD);
      if (state == S_SN_LD)
        snapshot[15:0] <= bus.readdata[15:0];
      if (state == S_SN_HD)
        snapshot[31:16] <= bus.readdata[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_interval_timer_driver.sv
// Randomized bench for interval_timer_driver against a transaction-script model of the driver,
// with a simple interval-timer slave model and directed literal checks.
module tb_interval_timer_driver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic [31:0] period = '0;
  logic        busy;
  logic        tick;
  logic [31:0] tick_count;
`ifdef INTERVAL_TIMER_DRIVER_SNAPSHOT_EN
  logic        snap_req = 1'b0;
  logic        snap_valid;
  logic [31:0] snapshot;
`endif

  interval_timer_driver_if #(.ADDR_W(3), .DATA_W(16)) bus ();

  interval_timer_driver #(.ADDR_W(3), .DATA_W(16), .TICK_CNT_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .period     (period),
    .continuous (continuous),
    .busy       (busy),
    .tick       (tick),
    .tick_count (tick_count),
`ifdef INTERVAL_TIMER_DRIVER_SNAPSHOT_EN
    .snap_req   (snap_req),
    .snap_valid (snap_valid),
    .snapshot   (snapshot),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  // Timer slave: TO latches on fire, clears on any status write; RUN reads as 1.
  logic        to_flag = 1'b0;
  logic        fire = 1'b0;
  logic        spur = 1'b0;
  logic [31:0] snap_val = 32'h0001_2345;
  assign bus.irq = to_flag | spur;

  always @(posedge clk) begin
    if (bus.chipselect && !bus.write_n && bus.address == 3'd0)
      to_flag <= 1'b0;
    else if (fire)
      to_flag <= 1'b1;
    if (bus.chipselect && bus.write_n)
      case (bus.address)
        3'd0:    bus.readdata <= {14'b0, 1'b1, to_flag};
        3'd4:    bus.readdata <= snap_val[15:0];
        3'd5:    bus.readdata <= snap_val[31:16];
        default: bus.readdata <= 16'h0000;
      endcase
    else
      bus.readdata <= 16'h0000;
  end

  // Driver model: each cycle is one scripted operation; finished operations push follow-on scripts.
  typedef enum int {K_IDLE, K_WAIT, K_BUS, K_DECIDE, K_CLR, K_STOP, K_SNLD, K_SNHD} kind_e;
  typedef struct {
    kind_e       kind;
    logic        cs;
    logic        wn;
    logic [2:0]  a;
    logic [15:0] d;
  } op_t;

  function automatic op_t mk(kind_e k, logic cs, logic wn, logic [2:0] a, logic [15:0] d);
    op_t o;
    o.kind = k; o.cs = cs; o.wn = wn; o.a = a; o.d = d;
    return o;
  endfunction

  op_t         q[$];
  op_t         cur;
  logic        m_cont;
  logic        m_stop_pend;
  logic        m_snap_pend;
  logic [31:0] m_cnt;
  logic        m_tick;
  logic        m_snapv;
  logic [31:0] m_snap;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      cur = mk(K_IDLE, 1'b0, 1'b1, 3'd0, 16'h0);
      m_cont = 1'b0; m_stop_pend = 1'b0; m_snap_pend = 1'b0;
      m_cnt = '0; m_tick = 1'b0; m_snapv = 1'b0; m_snap = '0;
    end else begin
      m_snapv = 1'b0;
      if (stop && cur.kind != K_IDLE && cur.kind != K_WAIT)
        m_stop_pend = 1'b1;
      case (cur.kind)
        K_IDLE:
          if (start) begin
            m_cont = continuous;
            q.push_back(mk(K_BUS, 1'b1, 1'b0, 3'd2, period[15:0]));
            q.push_back(mk(K_BUS, 1'b1, 1'b0, 3'd3, period[31:16]));
            q.push_back(mk(K_BUS, 1'b1, 1'b0, 3'd1, continuous ? 16'h0007 : 16'h0005));
            q.push_back(mk(K_WAIT, 1'b0, 1'b1, 3'd0, 16'h0));
          end else
            q.push_back(mk(K_IDLE, 1'b0, 1'b1, 3'd0, 16'h0));
        K_WAIT:
          if (stop || m_stop_pend)
            q.push_back(mk(K_STOP, 1'b1, 1'b0, 3'd1, 16'h0008));
          else if (bus.irq) begin
            q.push_back(mk(K_BUS, 1'b1, 1'b1, 3'd0, 16'h0));
            q.push_back(mk(K_DECIDE, 1'b0, 1'b1, 3'd0, 16'h0));
          end
`ifdef INTERVAL_TIMER_DRIVER_SNAPSHOT_EN
          else if (m_snap_pend) begin
            m_snap_pend = 1'b0;
            q.push_back(mk(K_BUS, 1'b1, 1'b0, 3'd4, 16'h0));
            q.push_back(mk(K_BUS, 1'b1, 1'b1, 3'd4, 16'h0));
            q.push_back(mk(K_SNLD, 1'b1, 1'b1, 3'd5, 16'h0));
            q.push_back(mk(K_SNHD, 1'b0, 1'b1, 3'd0, 16'h0));
          end
`endif
          else
            q.push_back(mk(K_WAIT, 1'b0, 1'b1, 3'd0, 16'h0));
        K_DECIDE:
          if (bus.readdata[0]) q.push_back(mk(K_CLR, 1'b1, 1'b0, 3'd0, 16'h0));
          else                 q.push_back(mk(K_WAIT, 1'b0, 1'b1, 3'd0, 16'h0));
        K_CLR:
          q.push_back(m_cont ? mk(K_WAIT, 1'b0, 1'b1, 3'd0, 16'h0) : mk(K_IDLE, 1'b0, 1'b1, 3'd0, 16'h0));
        K_STOP:
          q.push_back(mk(K_IDLE, 1'b0, 1'b1, 3'd0, 16'h0));
        K_SNLD:
          m_snap[15:0] = bus.readdata;
        K_SNHD: begin
          m_snap[31:16] = bus.readdata;
          m_snapv = 1'b1;
          q.push_back(mk(K_WAIT, 1'b0, 1'b1, 3'd0, 16'h0));
        end
        default: ;
      endcase
`ifdef INTERVAL_TIMER_DRIVER_SNAPSHOT_EN
      if (snap_req) m_snap_pend = 1'b1;
`endif
      if (q.size() == 0) q.push_back(mk(K_IDLE, 1'b0, 1'b1, 3'd0, 16'h0));
      cur = q.pop_front();
      m_tick = (cur.kind == K_CLR);
      if (m_tick) m_cnt = m_cnt + 32'd1;
      if (cur.kind == K_IDLE) m_stop_pend = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      check("chipselect", bus.chipselect, cur.cs);
      check("write_n",    bus.write_n, cur.wn);
      check("address",    bus.address, cur.a);
      check("writedata",  bus.writedata, cur.d);
      check("busy",       busy, cur.kind != K_IDLE);
      check("tick",       tick, m_tick);
      check("tick_count", tick_count, m_cnt);
`ifdef INTERVAL_TIMER_DRIVER_SNAPSHOT_EN
      check("snap_valid", snap_valid, m_snapv);
      check("snapshot",   snapshot, m_snap);
`endif
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_tick(input int n);
    int k = 0;
    while (tick !== 1'b1 && k < n) begin
      cyc();
      k++;
    end
    if (tick !== 1'b1) check("tick_timeout", {31'b0, tick}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  busy, 32'd0);
    check({tag, "_tick"},  tick, 32'd0);
    check({tag, "_count"}, tick_count, 32'd0);
    check({tag, "_cs"},    bus.chipselect, 32'd0);
    check({tag, "_wn"},    bus.write_n, 32'd1);
    check({tag, "_addr"},  bus.address, 32'd0);
    check({tag, "_wdata"}, bus.writedata, 32'd0);
  endtask

  task automatic start_run(input logic [31:0] p, input logic c);
    start = 1'b1; period = p; continuous = c;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    repeat (3) cyc();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    chk_en  = 1'b1;
    cyc();

    // Continuous run, period 49999
    start_run(32'd49999, 1'b1);
    check("pl_addr", bus.address, 32'd2);
    check("pl_data", bus.writedata, 32'h0000_C34F);
    check("pl_busy", busy, 32'd1);
    cyc();
    check("ph_addr", bus.address, 32'd3);
    check("ph_data", bus.writedata, 32'h0);
    cyc();
    check("ctl_addr", bus.address, 32'd1);
    check("ctl_data", bus.writedata, 32'h0007);
    fire = 1'b1; cyc(); fire = 1'b0;
    wait_tick(10);
    check("cnt_after_first", tick_count, 32'd1);
    cyc();
    check("back_wait_cs", bus.chipselect, 32'd0);
    check("back_wait_busy", busy, 32'd1);

    // Stop from WAIT_IRQ
    stop = 1'b1; cyc(); stop = 1'b0;
    check("stop_addr", bus.address, 32'd1);
    check("stop_data", bus.writedata, 32'h0008);
    cyc();
    check("stop_idle", busy, 32'd0);

    // One-shot, period 10
    start_run(32'd10, 1'b0);
    check("os_pl_data", bus.writedata, 32'h000A);
    cyc(); cyc();
    check("os_ctl_data", bus.writedata, 32'h0005);
    fire = 1'b1; cyc(); fire = 1'b0;
    wait_tick(10);
    check("os_cnt", tick_count, 32'd2);
    cyc();
    check("os_idle", busy, 32'd0);

    // Stop during WR_PH becomes pending and is honoured after WR_CTL
    start_run(32'h0001_0000, 1'b1);
    cyc(); stop = 1'b1;
    cyc(); stop = 1'b0;
    check("sp_ctl_addr", bus.address, 32'd1);
    cyc();
    cyc();
    check("sp_stop_data", bus.writedata, 32'h0008);
    cyc();
    check("sp_idle", busy, 32'd0);
    check("sp_cnt", tick_count, 32'd2);

    // Spurious irq (status reads 0x0002), then stop colliding with a real irq
    start_run(32'd5, 1'b1);
    cyc(); cyc();
    spur = 1'b1; cyc(); cyc(); spur = 1'b0;
    repeat (5) cyc();
    check("spur_cnt", tick_count, 32'd2);
    check("spur_busy", busy, 32'd1);
    fire = 1'b1; cyc(); fire = 1'b0; stop = 1'b1;
    cyc(); stop = 1'b0;
    check("collide_stop_data", bus.writedata, 32'h0008);
    cyc();
    check("collide_idle", busy, 32'd0);
    check("collide_to_kept", {31'b0, to_flag}, 32'd1);
    check("collide_cnt", tick_count, 32'd2);

`ifdef INTERVAL_TIMER_DRIVER_SNAPSHOT_EN
    begin
      int k = 0;
      force_clear: begin end
      start_run(32'd7, 1'b1);
      // to_flag is still set, so let the driver service it before asking for a snapshot
      repeat (10) cyc();
      snap_req = 1'b1; cyc(); snap_req = 1'b0;
      while (snap_valid !== 1'b1 && k < 20) begin cyc(); k++; end
      check("snap_valid_seen", {31'b0, snap_valid}, 32'd1);
      check("snap_value", snapshot, 32'h0001_2345);
      stop = 1'b1; cyc(); stop = 1'b0;
      repeat (3) cyc();
    end
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 7) == 0);
      stop       = ($urandom_range(0, 24) == 0);
      period     = $urandom;
      continuous = $urandom_range(0, 1);
      fire       = ($urandom_range(0, 5) == 0);
      spur       = ($urandom_range(0, 19) == 0);
`ifdef INTERVAL_TIMER_DRIVER_SNAPSHOT_EN
      snap_req   = ($urandom_range(0, 15) == 0);
      snap_val   = $urandom;
`endif
      cyc();
    end
    start = 1'b0; stop = 1'b0; fire = 1'b0; spur = 1'b0;
`ifdef INTERVAL_TIMER_DRIVER_SNAPSHOT_EN
    snap_req = 1'b0;
`endif

    // Asynchronous reset in the middle of programming
    start_run(32'h1234_5678, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    cyc();
    reset_n = 1'b1;
    repeat (5) cyc();
    check("post_reset_idle", busy, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
